controle_vedacao: RTL and testbench



---
 rtl/controle_vedacao.sv | 163 ++++++++++++++++
 tb/tb_controle_vedacao.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_vedacao.sv
// Sealing-station controller: seal timing, stopper magazine, bottle-removal
// watchdog and a latched, acknowledged alarm with a cause code.
// Optional seal counter port `total` is enabled by defining VEDACAO_CONTADOR_EN.
`timescale 1ns/1ps

module controle_vedacao #(
  parameter int unsigned SEAL_CYCLES = 4,
  parameter int unsigned CAPACITY    = 50,
  parameter int unsigned LOW_THRESH  = 5,
  parameter int unsigned TIMEOUT     = 64,
`ifdef VEDACAO_CONTADOR_EN
  parameter int unsigned CNT_W       = 16,
`endif
  localparam int unsigned CAP_W      = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             garrafa,
  input  logic             pos,
  input  logic             rolha,
  input  logic             recarga,
  input  logic             ack,
  output logic             ve,
  output logic             done,
  output logic             alarme,
  output logic [1:0]       falha,
  output logic [CAP_W-1:0] rolhas,
  output logic             estoque_baixo
`ifdef VEDACAO_CONTADOR_EN
  ,
  output logic [CNT_W-1:0] total
`endif
);

  // Timer holds SEAL_CYCLES-1, watchdog holds TIMEOUT-1
  localparam int unsigned TW = (SEAL_CYCLES > 1) ? $clog2(SEAL_CYCLES) : 1;
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] FalhaNone   = 2'b00;
  localparam logic [1:0] FalhaRolha  = 2'b01;
  localparam logic [1:0] FalhaPerda  = 2'b10;
  localparam logic [1:0] FalhaTravou = 2'b11;

  typedef enum logic [2:0] {StIdle, StSeal, StDone, StWaitLeave, StAlarm} state_e;

  state_e           r_state, w_state_nxt;
  logic [TW-1:0]    r_timer, w_timer_nxt;
  logic [WW-1:0]    r_wdog, w_wdog_nxt;
  logic [1:0]       r_falha, w_falha_nxt;
  logic [CAP_W-1:0] r_rolhas, w_rolhas_nxt;
  logic             w_seal_end;
  logic             w_cause_clear;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_timer  <= '0;
      r_wdog   <= '0;
      r_falha  <= FalhaNone;
      r_rolhas <= CAP_W'(CAPACITY);
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_wdog   <= w_wdog_nxt;
      r_falha  <= w_falha_nxt;
      r_rolhas <= w_rolhas_nxt;
    end
  end

  // Next-state logic, alarm latching and cause clearing
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_wdog_nxt    = r_wdog;
    w_falha_nxt   = r_falha;
    w_seal_end    = 1'b0;
    w_cause_clear = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_rolhas == '0 || !rolha) begin
          w_state_nxt = StAlarm;
          w_falha_nxt = FalhaRolha;
        end else if (garrafa && pos) begin
          w_state_nxt = StSeal;
          w_timer_nxt = TW'(SEAL_CYCLES - 1);
        end
      end
      StSeal: begin
        if (!garrafa || !pos) begin
          w_state_nxt = StAlarm;
          w_falha_nxt = FalhaPerda;
        end else if (r_timer == '0) begin
          w_state_nxt = StDone;
          w_seal_end  = 1'b1;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      StDone: begin
        w_state_nxt = StWaitLeave;
        w_wdog_nxt  = '0;
      end
      StWaitLeave: begin
        // Bottle must leave before the next seal can start
        if (!garrafa) begin
          w_state_nxt = StIdle;
        end else if (r_wdog == WW'(TIMEOUT - 1)) begin
          w_state_nxt = StAlarm;
          w_falha_nxt = FalhaTravou;
        end else begin
          w_wdog_nxt = r_wdog + WW'(1);
        end
      end
      StAlarm: begin
        case (r_falha)
          FalhaRolha:  w_cause_clear = (r_rolhas != '0) && rolha;
          FalhaPerda:  w_cause_clear = 1'b1;
          FalhaTravou: w_cause_clear = !garrafa;
          default:     w_cause_clear = 1'b1;
        endcase
        if (ack && w_cause_clear) begin
          w_state_nxt = StIdle;
          w_falha_nxt = FalhaNone;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Magazine: reload wins over a same-cycle decrement
  always_comb begin
    w_rolhas_nxt = r_rolhas;
    if (recarga) begin
      w_rolhas_nxt = CAP_W'(CAPACITY);
    end else if (w_seal_end && r_rolhas != '0) begin
      w_rolhas_nxt = r_rolhas - CAP_W'(1);
    end
  end

`ifdef VEDACAO_CONTADOR_EN
  logic [CNT_W-1:0] r_total;

  // Completed-seal counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total <= '0;
    end else if (w_seal_end) begin
      r_total <= r_total + CNT_W'(1);
    end
  end

  assign total = r_total;
`endif

  assign ve            = (r_state == StSeal);
  assign done          = (r_state == StDone);
  assign alarme        = (r_state == StAlarm);
  assign falha         = r_falha;
  assign rolhas        = r_rolhas;
  assign estoque_baixo = (32'(r_rolhas) <= LOW_THRESH);

endmodule

// File: tb/tb_controle_vedacao.sv
// Bench for controle_vedacao: vector table, randomized run against a
// behavioural model, and directed multi-cycle sequences on a small-magazine
// instance. Define VEDACAO_CONTADOR_EN to also check `total`.
`timescale 1ns/1ps

module tb_controle_vedacao;

  localparam int unsigned A_CAP = 50, A_LOW = 5, A_SEAL = 4, A_TO = 64;
  localparam int unsigned B_CAP = 3,  B_LOW = 1, B_SEAL = 2, B_TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, a_g, a_p, a_r, a_rc, a_ack;
  logic       a_ve, a_done, a_al, a_low;
  logic [1:0] a_falha;
  logic [5:0] a_rolhas;

  logic       rst_b, b_g, b_p, b_r, b_rc, b_ack;
  logic       b_ve, b_done, b_al, b_low;
  logic [1:0] b_falha;
  logic [1:0] b_rolhas;

`ifdef VEDACAO_CONTADOR_EN
  logic [15:0] a_total;
  logic [1:0]  b_total;
`endif

  controle_vedacao #(
    .SEAL_CYCLES(A_SEAL), .CAPACITY(A_CAP), .LOW_THRESH(A_LOW), .TIMEOUT(A_TO)
`ifdef VEDACAO_CONTADOR_EN
    , .CNT_W(16)
`endif
  ) u_dut_a (
    .clk(clk), .reset(rst_a), .garrafa(a_g), .pos(a_p), .rolha(a_r), .recarga(a_rc),
    .ack(a_ack), .ve(a_ve), .done(a_done), .alarme(a_al), .falha(a_falha),
    .rolhas(a_rolhas), .estoque_baixo(a_low)
`ifdef VEDACAO_CONTADOR_EN
    , .total(a_total)
`endif
  );

  controle_vedacao #(
    .SEAL_CYCLES(B_SEAL), .CAPACITY(B_CAP), .LOW_THRESH(B_LOW), .TIMEOUT(B_TO)
`ifdef VEDACAO_CONTADOR_EN
    , .CNT_W(2)
`endif
  ) u_dut_b (
    .clk(clk), .reset(rst_b), .garrafa(b_g), .pos(b_p), .rolha(b_r), .recarga(b_rc),
    .ack(b_ack), .ve(b_ve), .done(b_done), .alarme(b_al), .falha(b_falha),
    .rolhas(b_rolhas), .estoque_baixo(b_low)
`ifdef VEDACAO_CONTADOR_EN
    , .total(b_total)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int b_seals  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model of instance A: phase counters rather than a state code
  int m_cause, m_seal_left, m_wait_cnt, m_rolhas, m_total;
  bit m_done, m_wait;

  task automatic m_reset();
    m_cause = 0; m_seal_left = 0; m_wait_cnt = 0; m_rolhas = A_CAP; m_total = 0;
    m_done = 0; m_wait = 0;
  endtask

  task automatic m_step(input bit g, input bit p, input bit r, input bit rc, input bit ack);
    bit fin;
    bit clr;
    fin = 0;
    if (m_cause != 0) begin
      clr = (m_cause == 2) || (m_cause == 1 && m_rolhas > 0 && r) || (m_cause == 3 && !g);
      if (ack && clr) m_cause = 0;
    end else if (m_seal_left > 0) begin
      if (!(g && p)) begin
        m_cause = 2;
        m_seal_left = 0;
      end else begin
        m_seal_left--;
        if (m_seal_left == 0) begin
          m_done = 1;
          fin = 1;
        end
      end
    end else if (m_done) begin
      m_done = 0;
      m_wait = 1;
      m_wait_cnt = 0;
    end else if (m_wait) begin
      if (!g) m_wait = 0;
      else begin
        m_wait_cnt++;
        if (m_wait_cnt == A_TO) begin
          m_wait = 0;
          m_cause = 3;
        end
      end
    end else begin
      if (m_rolhas == 0 || !r) m_cause = 1;
      else if (g && p) m_seal_left = A_SEAL;
    end
    if (rc) m_rolhas = A_CAP;
    else if (fin && m_rolhas > 0) m_rolhas--;
    if (fin) m_total++;
  endtask

  task automatic cmp_model(input int n);
    logic [11:0] dv, mv;
    dv = {a_ve, a_done, a_al, a_falha, a_rolhas, a_low};
    mv = {m_seal_left > 0, m_done, m_cause != 0, 2'(m_cause), 6'(m_rolhas),
          m_rolhas <= A_LOW};
    chk($sformatf("rand@%0d {ve,done,al,falha,rolhas,low}", n), 32'(dv), 32'(mv));
`ifdef VEDACAO_CONTADOR_EN
    chk($sformatf("rand@%0d total", n), 32'(a_total), 32'(m_total % 65536));
`endif
  endtask

  // Drive a bottle into B until done is seen; returns positioned in the DONE cycle
  task automatic b_seal(input string tag);
    bit seen;
    seen = 0;
    b_g = 1; b_p = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (b_done) seen = 1;
    end
    if (seen) b_seals++;
    else chk({tag, " done timeout"}, 0, 1);
  endtask

  typedef struct {
    logic g, p, r, rc, ack;
    logic ve, done, al;
    logic [1:0] falha;
    int rolhas;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    tbl[0]  = '{1, 1, 1, 0, 0, 1, 0, 0, 2'd0, 50};
    tbl[1]  = '{1, 1, 1, 0, 0, 1, 0, 0, 2'd0, 50};
    tbl[2]  = '{1, 1, 1, 0, 0, 1, 0, 0, 2'd0, 50};
    tbl[3]  = '{1, 1, 1, 0, 0, 1, 0, 0, 2'd0, 50};
    tbl[4]  = '{1, 1, 1, 0, 0, 0, 1, 0, 2'd0, 49};
    tbl[5]  = '{1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 49};
    tbl[6]  = '{1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 49};
    tbl[7]  = '{0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 49};
    tbl[8]  = '{1, 1, 1, 0, 0, 1, 0, 0, 2'd0, 49};
    tbl[9]  = '{1, 1, 1, 0, 0, 1, 0, 0, 2'd0, 49};
    tbl[10] = '{1, 0, 1, 0, 0, 0, 0, 1, 2'd2, 49};
    tbl[11] = '{0, 0, 1, 0, 1, 0, 0, 0, 2'd0, 49};
    tbl[12] = '{0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 49};

    a_g = 0; a_p = 0; a_r = 1; a_rc = 0; a_ack = 0;
    b_g = 0; b_p = 0; b_r = 1; b_rc = 0; b_ack = 0;
    rst_a = 1; rst_b = 1;
    repeat (2) @(negedge clk);
    rst_a = 0; rst_b = 0;

    chk("reset ve", 32'(a_ve), 0);
    chk("reset done", 32'(a_done), 0);
    chk("reset alarme", 32'(a_al), 0);
    chk("reset falha", 32'(a_falha), 0);
    chk("reset rolhas", 32'(a_rolhas), A_CAP);
    chk("reset estoque_baixo", 32'(a_low), 0);
`ifdef VEDACAO_CONTADOR_EN
    chk("reset total", 32'(a_total), 0);
`endif

    // Vector table on A
    for (int i = 0; i < 13; i++) begin
      a_g = tbl[i].g; a_p = tbl[i].p; a_r = tbl[i].r; a_rc = tbl[i].rc; a_ack = tbl[i].ack;
      @(negedge clk);
      chk($sformatf("tbl%0d ve", i), 32'(a_ve), 32'(tbl[i].ve));
      chk($sformatf("tbl%0d done", i), 32'(a_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d alarme", i), 32'(a_al), 32'(tbl[i].al));
      chk($sformatf("tbl%0d falha", i), 32'(a_falha), 32'(tbl[i].falha));
      chk($sformatf("tbl%0d rolhas", i), 32'(a_rolhas), 32'(tbl[i].rolhas));
      chk($sformatf("tbl%0d low", i), 32'(a_low), 32'(tbl[i].rolhas <= A_LOW));
    end

    // Randomized run on A against the model
    a_ack = 0; a_rc = 0;
    rst_a = 1;
    @(negedge clk);
    rst_a = 0;
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      int gp;
      cmp_model(n);
      gp = (n / 500) % 3 == 0 ? 60 : ((n / 500) % 3 == 1 ? 85 : 99);
      a_g   = ($urandom_range(99) < gp);
      a_p   = ($urandom_range(99) < 97);
      a_r   = ($urandom_range(99) < 97);
      a_rc  = ($urandom_range(399) == 0);
      a_ack = ($urandom_range(99) < 30);
      m_step(a_g, a_p, a_r, a_rc, a_ack);
      @(negedge clk);
    end
    cmp_model(3000);
    a_g = 0; a_rc = 0; a_ack = 0; a_r = 1;

    // B: deplete the magazine and watch low stock
    for (int s = 0; s < 3; s++) begin
      b_seal($sformatf("b seal%0d", s));
      chk($sformatf("b seal%0d rolhas", s), 32'(b_rolhas), 32'(B_CAP - 1 - s));
      chk($sformatf("b seal%0d low", s), 32'(b_low), 32'((B_CAP - 1 - s) <= B_LOW));
      b_g = 0;
      repeat (2) @(negedge clk);
    end
    chk("b empty idle alarme", 32'(b_al), 0);
    b_g = 1; b_p = 1;
    @(negedge clk);
    chk("b empty alarme", 32'(b_al), 1);
    chk("b empty falha", 32'(b_falha), 1);
    chk("b empty ve", 32'(b_ve), 0);
    b_ack = 1;
    @(negedge clk);
    chk("b ack-only alarme", 32'(b_al), 1);
    b_ack = 0; b_rc = 1;
    @(negedge clk);
    chk("b reload rolhas", 32'(b_rolhas), B_CAP);
    chk("b reload still alarme", 32'(b_al), 1);
    b_rc = 0; b_g = 0; b_ack = 1;
    @(negedge clk);
    chk("b reload+ack alarme", 32'(b_al), 0);
    chk("b reload+ack falha", 32'(b_falha), 0);
    b_ack = 0;

    // B: jam watchdog
    b_seal("b jam");
    @(negedge clk);
    chk("b jam entry alarme", 32'(b_al), 0);
    repeat (B_TO - 1) @(negedge clk);
    chk("b jam before timeout", 32'(b_al), 0);
    @(negedge clk);
    chk("b jam alarme", 32'(b_al), 1);
    chk("b jam falha", 32'(b_falha), 3);
    b_ack = 1;
    @(negedge clk);
    chk("b jam ack bottle held", 32'(b_al), 1);
    b_g = 0;
    @(negedge clk);
    chk("b jam exit alarme", 32'(b_al), 0);
    chk("b jam exit falha", 32'(b_falha), 0);
    b_ack = 0;

    // B: reload on the DONE-entry edge
    b_g = 1; b_p = 1;
    @(negedge clk);
    chk("b rc seal1 ve", 32'(b_ve), 1);
    @(negedge clk);
    chk("b rc seal2 ve", 32'(b_ve), 1);
    b_rc = 1;
    @(negedge clk);
    chk("b rc done", 32'(b_done), 1);
    chk("b rc rolhas", 32'(b_rolhas), B_CAP);
    b_seals++;
    b_rc = 0; b_g = 0;
    repeat (2) @(negedge clk);
`ifdef VEDACAO_CONTADOR_EN
    chk("b total wrap", 32'(b_total), 32'(b_seals % 4));
`endif

    // B: asynchronous reset in the middle of a seal
    b_g = 1; b_p = 1;
    @(negedge clk);
    chk("b mid-seal ve", 32'(b_ve), 1);
    #2 rst_b = 1;
    #1;
    chk("b async reset ve", 32'(b_ve), 0);
    chk("b async reset done", 32'(b_done), 0);
    chk("b async reset rolhas", 32'(b_rolhas), B_CAP);
`ifdef VEDACAO_CONTADOR_EN
    chk("b async reset total", 32'(b_total), 0);
`endif
    b_g = 0; b_p = 0;
    @(negedge clk);
    rst_b = 0;
    @(negedge clk);
    chk("b after reset done", 32'(b_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
